// File: rtl/gshare_pst_pkg.sv
// Shared types and counter arithmetic for the gshare pattern table.
// Counter widths up to 31 bits are handled by the helper functions.
package gshare_pst_pkg;

    typedef enum logic {
        StInit,
        StRun
    } pst_state_e;

    // Weakly not-taken: MSB clear, all lower bits set (01 for a 2-bit counter).
    function automatic int unsigned init_val(input int unsigned cw);
        return (32'd1 << (cw - 32'd1)) - 32'd1;
    endfunction

    function automatic int unsigned sat_next(input int unsigned cnt, input logic up,
                                             input int unsigned cw);
        int unsigned max_v;
        max_v = (32'd1 << cw) - 32'd1;
        if (up) begin
            return (cnt >= max_v) ? max_v : cnt + 32'd1;
        end
        return (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
    endfunction

endpackage

// File: rtl/gshare_pattern_table_if.sv
// Predict/update bundle between fetch/execute (master) and the pattern table (slave).
interface gshare_pattern_table_if #(
    parameter int unsigned DW = 4,
    parameter int unsigned CW = 2,
    parameter int unsigned HW = 4
) ();
    logic [DW-1:0] pred_pc;
    logic [DW-1:0] pred_idx;
    logic [CW-1:0] pred_state;
    logic          pred_taken;
    logic          upd_valid;
    logic [DW-1:0] upd_idx;
    logic          upd_taken;
    logic [HW-1:0] hist;
    logic          ready;

    modport master (
        output pred_pc, upd_valid, upd_idx, upd_taken,
        input  pred_idx, pred_state, pred_taken, hist, ready
    );

    modport slave (
        input  pred_pc, upd_valid, upd_idx, upd_taken,
        output pred_idx, pred_state, pred_taken, hist, ready
    );
endinterface

// File: rtl/pst_sat_next.sv
// Combinational CW-bit saturating up/down counter step.
module pst_sat_next
    import gshare_pst_pkg::*;
#(
    parameter int unsigned CW = 2
) (
    input  logic [CW-1:0] cnt_i,
    input  logic          up_i,
    output logic [CW-1:0] nxt_o
);
    always_comb begin
        nxt_o = CW'(sat_next(32'(cnt_i), up_i, CW));
    end
endmodule

// File: rtl/gshare_pattern_table.sv
// Gshare direction predictor table with a self-initialising reset walk.
// Define GSHARE_PST_BYPASS_EN to forward a same-cycle update into the predict read.
module gshare_pattern_table
    import gshare_pst_pkg::*;
#(
    parameter int unsigned DW = 4,
    parameter int unsigned CW = 2,
    parameter int unsigned HW = 4
) (
    input logic               clk,
    input logic               reset,
    gshare_pattern_table_if.slave bus
);
    localparam int unsigned   Depth   = 2 ** DW;
    localparam logic [CW-1:0] InitVal = CW'(init_val(CW));
    localparam logic [DW-1:0] LastIdx = DW'(Depth - 1);

    pst_state_e    state_q, state_d;
    logic [DW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] hist_q, hist_d;
    logic [CW-1:0] mem_q [Depth];
    logic [CW-1:0] mem_d [Depth];

    logic          ready;
    logic          init_en;
    logic          upd_en;
    logic [CW-1:0] upd_cur;
    logic [CW-1:0] upd_nxt;
    logic [DW-1:0] idx;
    logic [CW-1:0] stored;
    logic [CW-1:0] state_out;

    // State register; the memory array itself is never reset, the walk refills it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StInit;
            ptr_q   <= '0;
            hist_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hist_q  <= hist_d;
        end
        mem_q <= mem_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:  if (ptr_q == LastIdx) state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        ready   = (state_q == StRun);
        init_en = (state_q == StInit);
        upd_en  = ready && bus.upd_valid;
    end

    assign upd_cur = mem_q[bus.upd_idx];

    pst_sat_next #(
        .CW(CW)
    ) u_sat_next (
        .cnt_i (upd_cur),
        .up_i  (bus.upd_taken),
        .nxt_o (upd_nxt)
    );

    always_comb begin
        ptr_d  = init_en ? ptr_q + DW'(1) : ptr_q;
        hist_d = hist_q;
        if (upd_en) begin
            // Shift left and drop the oldest bit; also correct for HW == 1.
            hist_d = HW'({hist_q, bus.upd_taken});
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (!reset) begin
            if (init_en) begin
                mem_d[ptr_q] = InitVal;
            end else if (upd_en) begin
                mem_d[bus.upd_idx] = upd_nxt;
            end
        end
    end

    always_comb begin
        idx    = bus.pred_pc ^ DW'(hist_q);
        stored = mem_q[idx];
`ifdef GSHARE_PST_BYPASS_EN
        state_out = (upd_en && (bus.upd_idx == idx)) ? upd_nxt : stored;
`else
        state_out = stored;
`endif
    end

    assign bus.pred_idx   = idx;
    assign bus.pred_state = state_out;
    assign bus.pred_taken = ready & state_out[CW-1];
    assign bus.hist       = hist_q;
    assign bus.ready      = ready;

endmodule

// File: tb/tb_gshare_pattern_table.sv
// Self-checking bench for gshare_pattern_table against an array/arithmetic reference model.
module tb_gshare_pattern_table;
    localparam int DW    = 4;
    localparam int CW    = 2;
    localparam int HW    = 4;
    localparam int Depth = 1 << DW;
    localparam int CMax  = (1 << CW) - 1;
    localparam int InitV = (1 << (CW - 1)) - 1;
    localparam int HMask = (1 << HW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    gshare_pattern_table_if #(.DW(DW), .CW(CW), .HW(HW)) bus ();

    gshare_pattern_table #(.DW(DW), .CW(CW), .HW(HW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    int m_mem [Depth];
    int m_hist = 0;
    int m_walk = 0;
    bit m_ready = 1'b0;

    function automatic int sat(input int c, input bit up);
        if (up) return (c < CMax) ? c + 1 : CMax;
        return (c > 0) ? c - 1 : 0;
    endfunction

    // Expected predict-port counter for the current inputs.
    function automatic int exp_state(input int pc);
        int i;
        int v;
        i = (pc ^ m_hist) & (Depth - 1);
        v = m_mem[i];
`ifdef GSHARE_PST_BYPASS_EN
        if (m_ready && bus.upd_valid && (int'(bus.upd_idx) == i)) v = sat(m_mem[i], bus.upd_taken);
`endif
        return v;
    endfunction

    // One clock: the model consumes the inputs present at the edge, then settle 1ns past it.
    task automatic tick();
        bit r, v, t;
        int ui;
        r = reset;
        v = bus.upd_valid;
        t = bus.upd_taken;
        ui = int'(bus.upd_idx);
        @(posedge clk);
        if (r) begin
            m_hist = 0;
            m_walk = 0;
            m_ready = 1'b0;
        end else if (!m_ready) begin
            m_mem[m_walk] = InitV;
            m_walk++;
            if (m_walk == Depth) m_ready = 1'b1;
        end else if (v) begin
            m_mem[ui] = sat(m_mem[ui], t);
            m_hist = ((m_hist << 1) | int'(t)) & HMask;
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.upd_valid = 1'b0;
        bus.upd_idx = '0;
        bus.upd_taken = 1'b0;
    endtask

    task automatic full_walk();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < Depth; k++) tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        bus.pred_pc = 4'hA;
        tick();
        tick();
        #1;
        n_checks++;
        if (bus.ready !== 1'b0 || bus.pred_taken !== 1'b0 || bus.hist !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b taken=%b hist=%h, required 0 0 0",
                     bus.ready, bus.pred_taken, bus.hist);
        end
        n_checks++;
        if (bus.pred_idx !== 4'hA) begin
            n_fail++;
            $display("FAIL reset_idx: pred_idx=%h, required a", bus.pred_idx);
        end
        reset = 1'b0;
        for (int k = 1; k <= Depth; k++) begin
            tick();
            n_checks++;
            if (bus.ready !== (k == Depth)) begin
                n_fail++;
                $display("FAIL init_ready k=%0d: ready=%b, required %b", k, bus.ready, k == Depth);
            end
        end
        for (int pc = 0; pc < Depth; pc++) begin
            bus.pred_pc = DW'(pc);
            #1;
            n_checks++;
            if (bus.pred_idx !== DW'(pc) || bus.pred_state !== CW'(InitV)
                || bus.pred_taken !== 1'b0) begin
                n_fail++;
                $display("FAIL init_sweep pc=%0d: idx=%h state=%b taken=%b, required %h %b 0",
                         pc, bus.pred_idx, bus.pred_state, bus.pred_taken, pc, CW'(InitV));
            end
        end
    endtask

    task automatic test_saturation();
        int up_exp [3] = '{2, 3, 3};
        full_walk();
        for (int k = 0; k < 3; k++) begin
            bus.upd_valid = 1'b1;
            bus.upd_idx = 4'd5;
            bus.upd_taken = 1'b1;
            tick();
            idle_inputs();
            bus.pred_pc = DW'(5 ^ m_hist);
            #1;
            n_checks++;
            if (bus.pred_idx !== 4'd5 || bus.pred_state !== CW'(up_exp[k])
                || bus.pred_taken !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_up k=%0d: idx=%h state=%b taken=%b, required 5 %b 1",
                         k, bus.pred_idx, bus.pred_state, bus.pred_taken, CW'(up_exp[k]));
            end
        end
        for (int k = 0; k < 3; k++) begin
            bus.upd_valid = 1'b1;
            bus.upd_idx = 4'd9;
            bus.upd_taken = 1'b0;
            tick();
            idle_inputs();
            bus.pred_pc = DW'(9 ^ m_hist);
            #1;
            n_checks++;
            if (bus.pred_idx !== 4'd9 || bus.pred_state !== 2'b00 || bus.pred_taken !== 1'b0) begin
                n_fail++;
                $display("FAIL sat_down k=%0d: idx=%h state=%b taken=%b, required 9 00 0",
                         k, bus.pred_idx, bus.pred_state, bus.pred_taken);
            end
        end
    endtask

    task automatic test_history();
        full_walk();
        for (int k = 0; k < 2; k++) begin
            bus.upd_valid = 1'b1;
            bus.upd_idx = 4'd0;
            bus.upd_taken = 1'b1;
            tick();
        end
        idle_inputs();
        bus.pred_pc = 4'h6;
        #1;
        n_checks++;
        if (bus.hist !== 4'b0011) begin
            n_fail++;
            $display("FAIL hist_shift: hist=%b, required 0011", bus.hist);
        end
        n_checks++;
        if (bus.pred_idx !== 4'h5) begin
            n_fail++;
            $display("FAIL hist_index: pred_idx=%h, required 5", bus.pred_idx);
        end
    endtask

    task automatic test_bypass();
        logic [CW-1:0] e;
        full_walk();
        bus.pred_pc = 4'd3;
        bus.upd_valid = 1'b1;
        bus.upd_idx = 4'd3;
        bus.upd_taken = 1'b1;
        #1;
`ifdef GSHARE_PST_BYPASS_EN
        e = 2'b10;
`else
        e = 2'b01;
`endif
        n_checks++;
        if (bus.pred_idx !== 4'd3 || bus.pred_state !== e || bus.pred_taken !== e[CW-1]) begin
            n_fail++;
            $display("FAIL bypass_same: idx=%h state=%b taken=%b, required 3 %b %b",
                     bus.pred_idx, bus.pred_state, bus.pred_taken, e, e[CW-1]);
        end
        tick();
        idle_inputs();
        bus.pred_pc = DW'(3 ^ m_hist);
        #1;
        n_checks++;
        if (bus.pred_idx !== 4'd3 || bus.pred_state !== 2'b10 || bus.pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_next: idx=%h state=%b taken=%b, required 3 10 1",
                     bus.pred_idx, bus.pred_state, bus.pred_taken);
        end
    endtask

    task automatic test_reset_midinit();
        full_walk();
        // Dirty a few entries so the repeated walk has something to restore.
        for (int k = 0; k < 4; k++) begin
            bus.upd_valid = 1'b1;
            bus.upd_idx = DW'(k * 3);
            bus.upd_taken = 1'b1;
            tick();
        end
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.upd_valid = 1'($urandom_range(0, 1));
            bus.upd_idx = DW'($urandom_range(0, Depth - 1));
            bus.upd_taken = 1'($urandom_range(0, 1));
            tick();
        end
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= Depth; k++) begin
            bus.upd_valid = 1'($urandom_range(0, 1));
            bus.upd_idx = DW'($urandom_range(0, Depth - 1));
            bus.upd_taken = 1'($urandom_range(0, 1));
            tick();
            n_checks++;
            if (bus.ready !== (k == Depth) || bus.hist !== 4'h0) begin
                n_fail++;
                $display("FAIL midinit k=%0d: ready=%b hist=%b, required %b 0000",
                         k, bus.ready, bus.hist, k == Depth);
            end
        end
        idle_inputs();
        for (int pc = 0; pc < Depth; pc++) begin
            bus.pred_pc = DW'(pc);
            #1;
            n_checks++;
            if (bus.pred_state !== CW'(InitV)) begin
                n_fail++;
                $display("FAIL midinit_sweep pc=%0d: state=%b, required %b",
                         pc, bus.pred_state, CW'(InitV));
            end
        end
    endtask

    task automatic test_random();
        int pc;
        int e;
        full_walk();
        for (int k = 0; k < 300; k++) begin
            pc = int'($urandom_range(0, Depth - 1));
            bus.pred_pc = DW'(pc);
            bus.upd_valid = 1'($urandom_range(0, 1));
            // Bias the update index towards a few entries so counters saturate.
            bus.upd_idx = DW'($urandom_range(0, 3) == 0 ? $urandom_range(0, Depth - 1)
                                                         : $urandom_range(0, 2));
            bus.upd_taken = 1'($urandom_range(0, 1));
            #1;
            e = exp_state(pc);
            n_checks++;
            if (bus.pred_idx !== DW'(pc ^ m_hist) || bus.pred_state !== CW'(e)
                || bus.pred_taken !== e[CW-1] || bus.hist !== HW'(m_hist)) begin
                n_fail++;
                $display("FAIL random k=%0d: idx=%h state=%b taken=%b hist=%b, required %h %b %b %b",
                         k, bus.pred_idx, bus.pred_state, bus.pred_taken, bus.hist,
                         DW'(pc ^ m_hist), CW'(e), e[CW-1], HW'(m_hist));
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < Depth; i++) m_mem[i] = 0;
        idle_inputs();
        bus.pred_pc = '0;
        test_reset();
        test_saturation();
        test_history();
        test_bypass();
        test_reset_midinit();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
